// File: rtl/asi_pkg.sv
// Shared definitions for the ASI master poll scheduler.
//   - asi_state_e : scheduler FSM states
//   - bus timing  : ASI bit time and default reply timeout / inter-frame pause
//   - widths      : slave address, decoder reply nibble, shared timer
package asi_pkg;

  localparam int ASI_ADDR_W       = 5;
  localparam int ASI_DATA_W       = 4;
  localparam int ASI_BIT_CYC      = 72;
  localparam int DEF_RESP_TIMEOUT = 1200;
  // Three bit times of bus silence between frames.
  localparam int DEF_PAUSE_CYC    = 3 * ASI_BIT_CYC;
  localparam int TIMER_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SEND,
    WAIT_TX,
    WAIT_RX,
    REC,
    PAUSE
  } asi_state_e;

endpackage

// File: rtl/asi_resp_timer.sv
// Clear/enable up-counter with a terminal-count flag, shared by the reply
// timeout and the inter-transaction pause.
// Ports:
//   clk_in, rst  : clock, synchronous active-low reset
//   clear        : synchronous clear to zero (wins over enable)
//   enable       : count up by one
//   limit        : terminal count value
//   tc           : count == limit
module asi_resp_timer
  import asi_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk_in) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/asi_poll_scheduler.sv
// ASI master cycle scheduler. Polls slaves 1..SLAVE_MAX round-robin through
// the Manchester encoder/decoder, interleaves at most one host transaction
// between cyclic polls, and records every result in the slave-status table.
// Optional feature macro: ASI_RETRY_EN -- failed transactions are repeated
// up to RETRY_MAX times before the last attempt is recorded.
// Ports:
//   clk_in, rst                       : clock, synchronous active-low reset
//   cyc_addr / cyc_wdata              : next cyclic poll address and its data
//   host_req/addr/wdata, host_ack     : host request handshake
//   host_done/rdata/fail              : host transaction result
//   enc_start/addr/data, enc_busy     : Manchester encoder frame interface
//   dec_valid/data/err                : Manchester decoder reply
//   slv_we/addr/rdata/ok              : slave-status table write port
//   cycle_done                        : poll pointer wrapped SLAVE_MAX -> 1
module asi_poll_scheduler
  import asi_pkg::*;
#(
  parameter int SLAVE_MAX    = 31,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
  parameter int PAUSE_CYC    = DEF_PAUSE_CYC,
  parameter int RETRY_MAX    = 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  output logic [ASI_ADDR_W-1:0] cyc_addr,
  input  logic [ASI_ADDR_W-1:0] cyc_wdata,
  input  logic                  host_req,
  input  logic [ASI_ADDR_W-1:0] host_addr,
  input  logic [ASI_ADDR_W-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  host_done,
  output logic [ASI_DATA_W-1:0] host_rdata,
  output logic                  host_fail,
  output logic                  enc_start,
  output logic [ASI_ADDR_W-1:0] enc_addr,
  output logic [ASI_ADDR_W-1:0] enc_data,
  input  logic                  enc_busy,
  input  logic                  dec_valid,
  input  logic [ASI_DATA_W-1:0] dec_data,
  input  logic                  dec_err,
  output logic                  slv_we,
  output logic [ASI_ADDR_W-1:0] slv_addr,
  output logic [ASI_DATA_W-1:0] slv_rdata,
  output logic                  slv_ok,
  output logic                  cycle_done
);

  asi_state_e state, next_state;

  logic [ASI_ADDR_W-1:0] poll_ptr;
  logic [ASI_DATA_W-1:0] rx_data;
  logic                  rx_ok;
  logic                  is_host;
  logic                  last_host;
  logic                  seen_busy;

  logic tmr_clear, tmr_enable, tmr_tc;
  logic [TIMER_W-1:0] tmr_limit;

  logic sel_host, rx_done, rx_good, at_max;
  logic can_retry, retry_now, redo;

  // Host wins SEL only if the previous transaction was cyclic, so a held
  // host_req can never starve the poll cycle.
  assign sel_host = host_req && !last_host;
  assign rx_good  = dec_valid && !dec_err;
  // A reply arriving in the timeout cycle still counts as a reply.
  assign rx_done  = (state == WAIT_RX) && (dec_valid || tmr_tc);
  assign at_max   = (poll_ptr == ASI_ADDR_W'(SLAVE_MAX));
  assign cyc_addr = poll_ptr;

  assign retry_now = (state == REC) && !rx_ok && can_retry;

  // Timer is zeroed in the state before each timed state.
  assign tmr_clear  = (state == WAIT_TX) || (state == REC);
  assign tmr_enable = (state == WAIT_RX) || (state == PAUSE);
  assign tmr_limit  = (state == PAUSE) ? TIMER_W'(PAUSE_CYC - 1)
                                       : TIMER_W'(RESP_TIMEOUT - 1);

  asi_resp_timer u_timer (
    .clk_in (clk_in),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .limit  (tmr_limit),
    .tc     (tmr_tc)
  );

`ifdef ASI_RETRY_EN
  logic [1:0] retry_cnt;

  assign can_retry = (int'(retry_cnt) < RETRY_MAX);

  // redo steers PAUSE back to SEND so the retry reuses the captured frame.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      retry_cnt <= '0;
      redo      <= 1'b0;
    end else if (state == SEL) begin
      retry_cnt <= '0;
      redo      <= 1'b0;
    end else if (state == REC) begin
      redo <= retry_now;
      if (retry_now) begin
        retry_cnt <= retry_cnt + 2'd1;
      end
    end
  end
`else
  // RETRY_MAX has no effect in this build; every first outcome is recorded.
  assign can_retry = 1'b0 & (RETRY_MAX != 0);
  assign redo      = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state     <= IDLE;
      poll_ptr  <= ASI_ADDR_W'(1);
      enc_addr  <= '0;
      enc_data  <= '0;
      is_host   <= 1'b0;
      last_host <= 1'b0;
      seen_busy <= 1'b0;
      rx_ok     <= 1'b0;
      rx_data   <= '0;
    end else begin
      state <= next_state;
      case (state)
        SEL: begin
          is_host   <= sel_host;
          last_host <= sel_host;
          enc_addr  <= sel_host ? host_addr  : poll_ptr;
          enc_data  <= sel_host ? host_wdata : cyc_wdata;
        end
        SEND: seen_busy <= 1'b0;
        WAIT_TX: begin
          if (enc_busy) begin
            seen_busy <= 1'b1;
          end
        end
        WAIT_RX: begin
          if (rx_done) begin
            rx_ok   <= rx_good;
            rx_data <= rx_good ? dec_data : '0;
          end
        end
        REC: begin
          if (!retry_now && !is_host) begin
            poll_ptr <= at_max ? ASI_ADDR_W'(1) : poll_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result outputs are held at zero except in the recording REC cycle.
  always_comb begin
    next_state = state;
    enc_start  = 1'b0;
    host_ack   = 1'b0;
    host_done  = 1'b0;
    host_rdata = '0;
    host_fail  = 1'b0;
    slv_we     = 1'b0;
    slv_addr   = '0;
    slv_rdata  = '0;
    slv_ok     = 1'b0;
    cycle_done = 1'b0;
    case (state)
      IDLE: next_state = SEL;
      SEL: begin
        host_ack   = sel_host;
        next_state = SEND;
      end
      SEND: begin
        enc_start  = 1'b1;
        next_state = WAIT_TX;
      end
      WAIT_TX: begin
        if (seen_busy && !enc_busy) begin
          next_state = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (rx_done) begin
          next_state = REC;
        end
      end
      REC: begin
        next_state = PAUSE;
        if (!retry_now) begin
          slv_we     = 1'b1;
          slv_addr   = enc_addr;
          slv_rdata  = rx_data;
          slv_ok     = rx_ok;
          host_done  = is_host;
          host_rdata = is_host ? rx_data : '0;
          host_fail  = is_host && !rx_ok;
          cycle_done = !is_host && at_max;
        end
      end
      PAUSE: begin
        if (tmr_tc) begin
          next_state = redo ? SEND : SEL;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_asi_poll_scheduler.sv
// Directed testbench for asi_poll_scheduler (SLAVE_MAX=3, short timers).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_asi_poll_scheduler;

  localparam int SLAVE_MAX    = 3;
  localparam int RESP_TIMEOUT = 50;
  localparam int PAUSE_CYC    = 10;
  localparam int RETRY_MAX    = 1;
  localparam int BUSY_CYC     = 3;
  localparam int BUDGET       = RESP_TIMEOUT + PAUSE_CYC + 20;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] cyc_addr;
  logic [4:0] cyc_wdata = 5'h15;
  logic       host_req = 1'b0;
  logic [4:0] host_addr = '0;
  logic [4:0] host_wdata = '0;
  logic       host_ack, host_done, host_fail;
  logic [3:0] host_rdata;
  logic       enc_start;
  logic [4:0] enc_addr, enc_data;
  logic       enc_busy = 1'b0;
  logic       dec_valid = 1'b0;
  logic [3:0] dec_data = '0;
  logic       dec_err = 1'b0;
  logic       slv_we, slv_ok, cycle_done;
  logic [4:0] slv_addr;
  logic [3:0] slv_rdata;

  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  int lat;
  int we_snap;
  logic       acked;
  logic [4:0] st_addr, st_data;
  logic [4:0] w_addr;
  logic [3:0] w_rdata, w_hrdata;
  logic       w_ok, w_cd, w_hd, w_hf;

  always #5 clk_in = ~clk_in;

  asi_poll_scheduler #(
    .SLAVE_MAX    (SLAVE_MAX),
    .RESP_TIMEOUT (RESP_TIMEOUT),
    .PAUSE_CYC    (PAUSE_CYC),
    .RETRY_MAX    (RETRY_MAX)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .cyc_addr   (cyc_addr),
    .cyc_wdata  (cyc_wdata),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_done  (host_done),
    .host_rdata (host_rdata),
    .host_fail  (host_fail),
    .enc_start  (enc_start),
    .enc_addr   (enc_addr),
    .enc_data   (enc_data),
    .enc_busy   (enc_busy),
    .dec_valid  (dec_valid),
    .dec_data   (dec_data),
    .dec_err    (dec_err),
    .slv_we     (slv_we),
    .slv_addr   (slv_addr),
    .slv_rdata  (slv_rdata),
    .slv_ok     (slv_ok),
    .cycle_done (cycle_done)
  );

  // Pulse counters used for handshake pairing and "no write" checks.
  always @(negedge clk_in) begin
    if (host_ack === 1'b1) ack_cnt++;
    if (host_done === 1'b1) done_cnt++;
    if (slv_we === 1'b1) we_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits for enc_start; acked reports whether host_ack was seen on the way.
  task automatic waitStart(output logic ack_o);
    int n = 0;
    ack_o = 1'b0;
    while (enc_start !== 1'b1 && n < BUDGET) begin
      ack_o = ack_o | (host_ack === 1'b1);
      @(negedge clk_in);
      dec_valid = 1'b0;
      n++;
    end
    checkOutput("enc_start_seen", enc_start, 1'b1);
  endtask

  // Plays one frame: encoder busy for BUSY_CYC cycles, then a reply
  // 'delay' cycles into WAIT_RX (delay < 0: no reply). Returns on the
  // falling edge where dec_valid was raised, or where enc_busy dropped.
  task automatic applyStimulus(input int delay, input logic [3:0] data,
                               input logic err);
    waitStart(acked);
    st_addr  = enc_addr;
    st_data  = enc_data;
    enc_busy = 1'b1;
    repeat (BUSY_CYC) @(negedge clk_in);
    enc_busy = 1'b0;
    if (delay >= 0) begin
      repeat (delay + 1) @(negedge clk_in);
      dec_valid = 1'b1;
      dec_data  = data;
      dec_err   = err;
    end
  endtask

  task automatic waitWrite();
    lat = 0;
    while (slv_we !== 1'b1 && lat < BUDGET) begin
      @(negedge clk_in);
      dec_valid = 1'b0;
      lat++;
    end
    checkOutput("slv_we_seen", slv_we, 1'b1);
    w_addr   = slv_addr;
    w_rdata  = slv_rdata;
    w_ok     = slv_ok;
    w_cd     = cycle_done;
    w_hd     = host_done;
    w_hf     = host_fail;
    w_hrdata = host_rdata;
  endtask

  initial begin
    logic [4:0] exp_addr [4];
    exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd3; exp_addr[3] = 5'd1;

    // Reset state
    @(negedge clk_in);
    checkOutput("rst_cyc_addr", cyc_addr, 5'd1);
    checkOutput("rst_outputs",
                {host_ack, host_done, host_rdata, host_fail, enc_start, enc_addr,
                 enc_data, slv_we, slv_addr, slv_rdata, slv_ok, cycle_done}, '0);
    rst = 1'b1;
    @(negedge clk_in);
    checkOutput("start_not_early", enc_start, 1'b0);
    @(negedge clk_in);
    checkOutput("start_2_after_rst", enc_start, 1'b1);

    // Cyclic wrap: every slave answers 4'hA
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, 4'hA, 1'b0);
      checkOutput("wrap_enc_addr", st_addr, exp_addr[i]);
      checkOutput("wrap_enc_data", st_data, 5'h15);
      waitWrite();
      checkOutput("wrap_latency", lat, 1);
      checkOutput("wrap_slv_addr", w_addr, exp_addr[i]);
      checkOutput("wrap_slv_ok", w_ok, 1'b1);
      checkOutput("wrap_slv_rdata", w_rdata, 4'hA);
      checkOutput("wrap_cycle_done", w_cd, exp_addr[i] == 5'd3);
    end

    // Timeout: slave 2 silent; counted from the cycle enc_busy first reads low
    applyStimulus(-1, 4'h0, 1'b0);
    checkOutput("to_enc_addr", st_addr, 5'd2);
    waitWrite();
    checkOutput("to_latency", lat, RESP_TIMEOUT + 1);
    checkOutput("to_slv_addr", w_addr, 5'd2);
    checkOutput("to_slv_ok", w_ok, 1'b0);
    checkOutput("to_slv_rdata", w_rdata, 4'h0);

    // Collision: reply lands in the timeout cycle
    applyStimulus(RESP_TIMEOUT - 1, 4'h6, 1'b0);
    checkOutput("col_enc_addr", st_addr, 5'd3);
    waitWrite();
    checkOutput("col_latency", lat, 1);
    checkOutput("col_slv_ok", w_ok, 1'b1);
    checkOutput("col_slv_rdata", w_rdata, 4'h6);
    checkOutput("col_cycle_done", w_cd, 1'b1);

    // Parity error on slave 1
    applyStimulus(2, 4'hF, 1'b1);
    checkOutput("par_enc_addr", st_addr, 5'd1);
`ifdef ASI_RETRY_EN
    we_snap = we_cnt;
    applyStimulus(2, 4'h5, 1'b0);
    checkOutput("par_no_first_write", we_cnt, we_snap);
    checkOutput("par_retry_addr", st_addr, 5'd1);
    checkOutput("par_retry_data", st_data, 5'h15);
    waitWrite();
    checkOutput("par_slv_addr", w_addr, 5'd1);
    checkOutput("par_slv_ok", w_ok, 1'b1);
    checkOutput("par_slv_rdata", w_rdata, 4'h5);
`else
    waitWrite();
    checkOutput("par_slv_addr", w_addr, 5'd1);
    checkOutput("par_slv_ok", w_ok, 1'b0);
    checkOutput("par_slv_rdata", w_rdata, 4'h0);
`endif

    // Host fairness: host_req held; host, cyclic, host
    host_req   = 1'b1;
    host_addr  = 5'd7;
    host_wdata = 5'h0C;
    ack_cnt    = 0;
    done_cnt   = 0;
    applyStimulus(1, 4'h3, 1'b0);
    checkOutput("h1_ack", acked, 1'b1);
    checkOutput("h1_enc_addr", st_addr, 5'd7);
    checkOutput("h1_enc_data", st_data, 5'h0C);
    waitWrite();
    checkOutput("h1_slv_addr", w_addr, 5'd7);
    checkOutput("h1_done", w_hd, 1'b1);
    checkOutput("h1_rdata", w_hrdata, 4'h3);
    checkOutput("h1_fail", w_hf, 1'b0);
    checkOutput("h1_cycle_done", w_cd, 1'b0);

    applyStimulus(1, 4'h9, 1'b0);
    checkOutput("c_ack", acked, 1'b0);
    checkOutput("c_enc_addr", st_addr, 5'd2);
    waitWrite();
    checkOutput("c_slv_addr", w_addr, 5'd2);
    checkOutput("c_host_done", w_hd, 1'b0);
    checkOutput("c_slv_rdata", w_rdata, 4'h9);

    applyStimulus(-1, 4'h0, 1'b0);
    checkOutput("h2_ack", acked, 1'b1);
    checkOutput("h2_enc_addr", st_addr, 5'd7);
    waitWrite();
    host_req = 1'b0;
    checkOutput("h2_slv_addr", w_addr, 5'd7);
    checkOutput("h2_done", w_hd, 1'b1);
    checkOutput("h2_fail", w_hf, 1'b1);
    checkOutput("h2_rdata", w_hrdata, 4'h0);
    checkOutput("h2_slv_ok", w_ok, 1'b0);

    // Reset in the middle of WAIT_RX for slave 3
    applyStimulus(-1, 4'h0, 1'b0);
    checkOutput("host_ack_count", ack_cnt, 2);
    checkOutput("host_done_count", done_cnt, 2);
    checkOutput("rr_enc_addr", st_addr, 5'd3);
    we_snap = we_cnt;
    repeat (5) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    checkOutput("rr_cyc_addr", cyc_addr, 5'd1);
    checkOutput("rr_outputs",
                {host_ack, host_done, host_rdata, host_fail, enc_start, enc_addr,
                 enc_data, slv_we, slv_addr, slv_rdata, slv_ok, cycle_done}, '0);
    rst = 1'b1;
    @(negedge clk_in);
    checkOutput("rr_start_not_early", enc_start, 1'b0);
    @(negedge clk_in);
    checkOutput("rr_start", enc_start, 1'b1);
    checkOutput("rr_next_addr", enc_addr, 5'd1);
    checkOutput("rr_no_write", we_cnt, we_snap);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
